fp32_div: RTL and testbench
===========================

# fp32_div

Sequential IEEE-754 single-precision divider: the inverse-direction companion to the team's combinational FP32 multiplier in the FPU datapath. It computes A/B with a radix-2 restoring mantissa divider, one quotient bit per cycle. It exposes valid/ready handshakes on both sides so the FPU issue logic can stall on it. Its flag and special-value conventions match the multiplier's, so the ALU result mux treats both units identically.

## Interface
- No parameters; widths are fixed by FP32.
- `clk  in  1`: single clock, rising edge.
- `rst_n  in  1`: synchronous, active-low reset.
- `in_valid  in  1`: operands A, B are valid.
- `in_ready  out  1`: divider can accept operands.
- `A  in  32`: dividend, FP32.
- `B  in  32`: divisor, FP32.
- `out_valid  out  1`: result and flags are valid.
- `out_ready  in  1`: consumer accepts the result.
- `result  out  32`: quotient, FP32.
- `overflow  out  1`: exponent overflow, or divide by zero.
- `underflow  out  1`: exponent underflow; result is flushed to signed zero.
- `div_by_zero  out  1`: B is zero or denormal while A is normal.

## Operation
- **States:** IDLE, DIV, NORM, DONE.
- `in_ready` = (state == IDLE).
- A transfer occurs on a cycle with `in_valid & in_ready`.
- **On accept:**
  - Register sign = A[31]^B[31].
  - Register 24-bit mantissas with the hidden bit set.
  - Register the 10-bit signed exponent e = A[30:23] − B[30:23] + 127.
- **Special cases** are resolved at accept and go directly to DONE. Priority order:
  1. A or B exponent == 8'hFF → result 32'd0, all flags 0.
  2. A exponent == 0 (zero/denormal, flushed) → {sign, 31'd0}, flags 0.
  3. B exponent == 0 → {sign, 8'hFF, 23'd0}, overflow = 1, div_by_zero = 1.
- **DIV:**
  - 26 iterations produce quotient q[25:0] of ma/mb MSB-first, with a 25-bit partial remainder.
  - Each iteration: trial subtract; set the q bit if the result is non-negative; shift left.
  - A 5-bit counter runs 25 down to 0.
- **NORM:**
  - Leading-bit select:
    - If q[25] = 1: mant = q[24:2], guard = q[1], sticky = q[0] | (rem ≠ 0).
    - Else: mant = q[23:1], guard = q[0], sticky = (rem ≠ 0), and e = e − 1.
  - Rounding: mant + (guard & sticky). This is the multiplier's rounding rule, not RNE.
  - A rounding carry-out zeroes mant and sets e = e + 1.
  - If e ≥ 255: {sign, 8'hFF, 23'd0}, overflow = 1.
  - Else if e ≤ 0: {sign, 31'd0}, underflow = 1.
  - Else: {sign, e[7:0], mant}.
- **DONE:**
  - `out_valid` = 1.
  - `result` and flags are held stable until `out_ready`.
  - On `out_valid & out_ready`, go to IDLE.
- **Boundaries:**
  - `in_valid` during a busy state is ignored. No queuing; the producer must hold.
  - Operands are not re-sampled mid-division.

## Timing
- **Reset:** on a `rst_n` = 0 sample at any rising edge, from any state:
  - state ← IDLE, `out_valid` = 0, `in_ready` = 1.
  - `result` = 0, `overflow` = `underflow` = `div_by_zero` = 0.
  - An in-flight operation is discarded.
- **Normal path**, accept at edge T:
  - DIV during edges T+1..T+26.
  - NORM at edge T+27.
  - `out_valid` is high after edge T+27, giving a latency of 27 cycles.
- **Special path:** `out_valid` is high after edge T+1.
- **Handshake:**
  - `out_ready` held high: return to IDLE on the first DONE cycle. The next accept is possible one cycle later, so peak throughput is one operation per 29 cycles.
  - `out_ready` low: DONE persists indefinitely with outputs constant.
- **Registered vs. combinational outputs:**
  - All outputs are registered.
  - `in_ready` and `out_valid` are decoded from registered state only, with no combinational path from `in_valid` or `out_ready`.

## Structure
- Shared FPU package `fpu_pkg` holds:
  - FP32 field constants: EXP_BIAS = 127, EXP_MAX = 8'hFF, MANT_W = 23.
  - The state enum type.
  - A function that classifies an operand as zero/denormal, normal, or inf/NaN. The multiplier reuses this function.
- One natural sub-module, `fp32_div_core`, contains the mantissa restoring-division datapath:
  - Remainder and quotient registers, plus the iteration counter.
  - Start/done strobes.
- The top level owns the FSM, exponent arithmetic, special cases, rounding and the handshake.

## Test plan
- 0x40C00000 / 0x40000000 (6/2) → result 0x40400000, flags 0, `out_valid` exactly 27 cycles after accept.
- 0x3F800000 / 0x40400000 (1/3) → 0x3EAAAAAB (guard = 1, sticky = 1 rounds up).
- 0x3F800000 / 0x00000000 → 0x7F800000, overflow = 1, div_by_zero = 1, `out_valid` 1 cycle after accept.
- Exponent edges:
  - 0x7F000000 / 0x3E800000 → 0x7F800000, overflow = 1.
  - 0x00800000 / 0x40000000 → 0x00000000, underflow = 1.
  - 0x7FC00000 / any → 0x00000000, flags 0.
- Backpressure:
  - Hold `out_ready` = 0 for 10 cycles in DONE → `result` is stable and `in_ready` stays 0.
  - Pulse `in_valid` with new operands mid-DIV → they are ignored.
- Reset mid-DIV (cycle 12):
  - All outputs are 0 and `in_ready` = 1 on the next cycle.
  - A following 6/2 operation yields 0x40400000.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared FPU definitions: FP32 field constants, operand payload layout,
// FSM state encoding and the operand classifier used by the divider and multiplier.
package fpu_pkg;

    localparam int unsigned EXP_BIAS = 127;
    localparam logic [7:0]  EXP_MAX  = 8'hFF;
    localparam int unsigned MANT_W   = 23;
    localparam int unsigned SIG_W    = MANT_W + 1;   // mantissa with hidden bit
    localparam int unsigned QUO_W    = SIG_W + 2;    // quotient bits produced by the divider
    localparam int unsigned REM_W    = SIG_W + 1;    // partial remainder width
    localparam int unsigned EXP_W    = 10;           // signed working exponent
    localparam int unsigned CNT_W    = 5;            // iteration counter width

    // FP32 operand fields
    typedef struct packed {
        logic              sgn;
        logic [7:0]        expo;
        logic [MANT_W-1:0] mant;
    } fp32_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DIV  = 2'd1,
        ST_NORM = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        FP_ZERO   = 2'd0,   // zero or denormal (flushed)
        FP_NORMAL = 2'd1,
        FP_INFNAN = 2'd2
    } fp_class_t;

    // Classify an operand from its biased exponent field
    function automatic fp_class_t fp_classify(input logic [7:0] expo);
        fp_class_t cls;
        if (expo == EXP_MAX) begin
            cls = FP_INFNAN;
        end else if (expo == 8'd0) begin
            cls = FP_ZERO;
        end else begin
            cls = FP_NORMAL;
        end
        return cls;
    endfunction

endpackage

// File: rtl/fp32_div_core.sv
// Radix-2 restoring mantissa divider, one quotient bit per clock.
// Ports: clk, rst_n (sync, active-low); start loads ma/mb; done_c is high
// during the final iteration cycle; q/rem hold the quotient and final
// (left-shifted) partial remainder until the next start.
module fp32_div_core
    import fpu_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [SIG_W-1:0] ma,
    input  logic [SIG_W-1:0] mb,
    output logic             done_c,
    output logic [QUO_W-1:0] q,
    output logic [REM_W-1:0] rem
);

    localparam logic [CNT_W-1:0] ITER_LAST = CNT_W'(QUO_W - 1);

    logic [SIG_W-1:0] mb_q;
    logic [CNT_W-1:0] cnt;
    logic             running;
    logic [REM_W:0]   trial_c;
    logic             bit_c;
    logic [REM_W-1:0] keep_c;

    // Trial subtract; a clear sign bit means the divisor fits
    always_comb begin
        trial_c = {1'b0, rem} - {2'b00, mb_q};
        bit_c   = ~trial_c[REM_W];
        keep_c  = bit_c ? trial_c[REM_W-1:0] : rem;
    end

    assign done_c = running & (cnt == '0);

    // Iteration registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mb_q    <= '0;
            cnt     <= '0;
            running <= 1'b0;
            q       <= '0;
            rem     <= '0;
        end else if (start) begin
            mb_q    <= mb;
            cnt     <= ITER_LAST;
            running <= 1'b1;
            q       <= '0;
            rem     <= REM_W'(ma);
        end else if (running) begin
            q   <= {q[QUO_W-2:0], bit_c};
            rem <= REM_W'({keep_c, 1'b0});
            cnt <= cnt - 1'b1;
            if (cnt == '0) begin
                running <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/fp32_div.sv
// Sequential FP32 divider (A/B) with valid/ready handshakes on both sides.
// Ports: clk, rst_n (sync, active-low); in_valid/in_ready with operands A, B;
// out_valid/out_ready with result and overflow/underflow/div_by_zero flags.
// Special operands are resolved at accept; normal operands run 26 divider
// iterations followed by one normalise/round cycle.
module fp32_div
    import fpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        overflow,
    output logic        underflow,
    output logic        div_by_zero
);

    state_t                  state, state_d;
    logic                    sign_q, sign_d;
    logic signed [EXP_W-1:0] exp_q, exp_d;
    logic                    special_q, special_d;
    logic [31:0]             result_d;
    logic                    ovf_d, unf_d, dbz_d;
    logic                    start_c;

    fp32_t                   a_f, b_f;
    fp_class_t               cls_a, cls_b;

    logic                    core_done_c;
    logic [QUO_W-1:0]        quo;
    logic [REM_W-1:0]        rem;

    logic [MANT_W-1:0]       mant_c, mant_r_c;
    logic                    guard_c, sticky_c, carry_c;
    logic signed [EXP_W-1:0] e_pre_c, e_fin_c;

    assign a_f   = A;
    assign b_f   = B;
    assign cls_a = fp_classify(a_f.expo);
    assign cls_b = fp_classify(b_f.expo);

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);

    fp32_div_core u_core (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start_c),
        .ma     ({1'b1, a_f.mant}),
        .mb     ({1'b1, b_f.mant}),
        .done_c (core_done_c),
        .q      (quo),
        .rem    (rem)
    );

    // Leading-bit select and guard/sticky rounding of the raw quotient
    always_comb begin
        if (quo[QUO_W-1]) begin
            mant_c   = quo[QUO_W-2:2];
            guard_c  = quo[1];
            sticky_c = quo[0] | (|rem);
            e_pre_c  = exp_q;
        end else begin
            mant_c   = quo[QUO_W-3:1];
            guard_c  = quo[0];
            sticky_c = |rem;
            e_pre_c  = exp_q - 10'sd1;
        end
        {carry_c, mant_r_c} = {1'b0, mant_c} + SIG_W'(guard_c & sticky_c);
        // a carry-out leaves mant_r_c at zero and bumps the exponent
        e_fin_c = e_pre_c + $signed({{(EXP_W-1){1'b0}}, carry_c});
    end

    // Next-state and next-output logic
    always_comb begin
        state_d   = state;
        sign_d    = sign_q;
        exp_d     = exp_q;
        special_d = special_q;
        result_d  = result;
        ovf_d     = overflow;
        unf_d     = underflow;
        dbz_d     = div_by_zero;
        start_c   = 1'b0;

        case (state)
            ST_IDLE: begin
                if (in_valid) begin
                    sign_d    = a_f.sgn ^ b_f.sgn;
                    exp_d     = $signed({2'b00, a_f.expo} - {2'b00, b_f.expo} + EXP_W'(EXP_BIAS));
                    special_d = 1'b1;
                    ovf_d     = 1'b0;
                    unf_d     = 1'b0;
                    dbz_d     = 1'b0;
                    // special results still pass through the finalise cycle
                    state_d   = ST_NORM;
                    if (cls_a == FP_INFNAN || cls_b == FP_INFNAN) begin
                        result_d = '0;
                    end else if (cls_a == FP_ZERO) begin
                        result_d = {sign_d, 31'd0};
                    end else if (cls_b == FP_ZERO) begin
                        result_d = {sign_d, EXP_MAX, {MANT_W{1'b0}}};
                        ovf_d    = 1'b1;
                        dbz_d    = 1'b1;
                    end else begin
                        special_d = 1'b0;
                        start_c   = 1'b1;
                        state_d   = ST_DIV;
                    end
                end
            end
            ST_DIV: begin
                if (core_done_c) begin
                    state_d = ST_NORM;
                end
            end
            ST_NORM: begin
                state_d = ST_DONE;
                if (!special_q) begin
                    ovf_d = 1'b0;
                    unf_d = 1'b0;
                    dbz_d = 1'b0;
                    if (e_fin_c >= 10'sd255) begin
                        result_d = {sign_q, EXP_MAX, {MANT_W{1'b0}}};
                        ovf_d    = 1'b1;
                    end else if (e_fin_c <= 10'sd0) begin
                        result_d = {sign_q, 31'd0};
                        unf_d    = 1'b1;
                    end else begin
                        result_d = {sign_q, e_fin_c[7:0], mant_r_c};
                    end
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            sign_q      <= 1'b0;
            exp_q       <= '0;
            special_q   <= 1'b0;
            result      <= '0;
            overflow    <= 1'b0;
            underflow   <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            state       <= state_d;
            sign_q      <= sign_d;
            exp_q       <= exp_d;
            special_q   <= special_d;
            result      <= result_d;
            overflow    <= ovf_d;
            underflow   <= unf_d;
            div_by_zero <= dbz_d;
        end
    end

endmodule

// File: tb/tb_fp32_div.sv
// Directed self-checking bench for fp32_div: arithmetic results, special
// operands, exponent edges, latency, backpressure, busy-time input and reset.
module tb_fp32_div;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] A;
    logic [31:0] B;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        overflow;
    logic        underflow;
    logic        div_by_zero;

    int total = 0;
    int bad   = 0;

    fp32_div dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .A           (A),
        .B           (B),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .result      (result),
        .overflow    (overflow),
        .underflow   (underflow),
        .div_by_zero (div_by_zero)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Wait (bounded) at a falling edge until the divider is idle
    task automatic wait_idle();
        int guard;
        guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
    endtask

    // One transaction; lat = edges after the accepting edge until out_valid
    task automatic do_op(input logic [31:0] a, input logic [31:0] b, output int lat,
                         output logic [31:0] res, output logic [2:0] fl, output bit ok);
        wait_idle();
        A        = a;
        B        = b;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        ok  = out_valid;
        res = result;
        fl  = {overflow, underflow, div_by_zero};
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        A         = '0;
        B         = '0;
        repeat (3) @(posedge clk);
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset in_ready got %b want 1", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset out_valid got %b want 0", out_valid); end
        total++; if (result !== 32'h0) begin bad++; $display("FAIL reset result got %h want 00000000", result); end
        total++; if ({overflow, underflow, div_by_zero} !== 3'b000)
            begin bad++; $display("FAIL reset flags got %b want 000", {overflow, underflow, div_by_zero}); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_arith();
        logic [31:0] va [5];
        logic [31:0] vb [5];
        logic [31:0] vr [5];
        int lat; logic [31:0] res; logic [2:0] fl; bit ok;
        va = '{32'h40C00000, 32'h3F800000, 32'hC0C00000, 32'h3F800000, 32'h40000000};
        vb = '{32'h40000000, 32'h40400000, 32'h40000000, 32'h3F800000, 32'h40400000};
        vr = '{32'h40400000, 32'h3EAAAAAB, 32'hC0400000, 32'h3F800000, 32'h3F2AAAAB};
        for (int i = 0; i < 5; i++) begin
            do_op(va[i], vb[i], lat, res, fl, ok);
            total++; if (!ok || res !== vr[i]) begin bad++; $display("FAIL arith[%0d] result got %h want %h", i, res, vr[i]); end
            total++; if (fl !== 3'b000) begin bad++; $display("FAIL arith[%0d] flags got %b want 000", i, fl); end
            total++; if (lat !== 27) begin bad++; $display("FAIL arith[%0d] latency got %0d want 27", i, lat); end
        end
    endtask

    task automatic test_special();
        logic [31:0] va [7];
        logic [31:0] vb [7];
        logic [31:0] vr [7];
        logic [2:0]  vf [7];
        int lat; logic [31:0] res; logic [2:0] fl; bit ok;
        va = '{32'h3F800000, 32'h7FC00000, 32'h00000000, 32'h80000000, 32'h7F800000, 32'h3F800000, 32'hBF800000};
        vb = '{32'h00000000, 32'h40000000, 32'h40000000, 32'h40000000, 32'h00000000, 32'h00400000, 32'h00000000};
        vr = '{32'h7F800000, 32'h00000000, 32'h00000000, 32'h80000000, 32'h00000000, 32'h7F800000, 32'hFF800000};
        vf = '{3'b101,       3'b000,       3'b000,       3'b000,       3'b000,       3'b101,       3'b101};
        for (int i = 0; i < 7; i++) begin
            do_op(va[i], vb[i], lat, res, fl, ok);
            total++; if (!ok || res !== vr[i]) begin bad++; $display("FAIL special[%0d] result got %h want %h", i, res, vr[i]); end
            total++; if (fl !== vf[i]) begin bad++; $display("FAIL special[%0d] flags got %b want %b", i, fl, vf[i]); end
            total++; if (lat !== 1) begin bad++; $display("FAIL special[%0d] latency got %0d want 1", i, lat); end
        end
    endtask

    task automatic test_exp_edges();
        logic [31:0] va [3];
        logic [31:0] vb [3];
        logic [31:0] vr [3];
        logic [2:0]  vf [3];
        int lat; logic [31:0] res; logic [2:0] fl; bit ok;
        va = '{32'h7F000000, 32'h00800000, 32'h80800000};
        vb = '{32'h3E800000, 32'h40000000, 32'h40000000};
        vr = '{32'h7F800000, 32'h00000000, 32'h80000000};
        vf = '{3'b100,       3'b010,       3'b010};
        for (int i = 0; i < 3; i++) begin
            do_op(va[i], vb[i], lat, res, fl, ok);
            total++; if (!ok || res !== vr[i]) begin bad++; $display("FAIL edge[%0d] result got %h want %h", i, res, vr[i]); end
            total++; if (fl !== vf[i]) begin bad++; $display("FAIL edge[%0d] flags got %b want %b", i, fl, vf[i]); end
            total++; if (lat !== 27) begin bad++; $display("FAIL edge[%0d] latency got %0d want 27", i, lat); end
        end
    endtask

    task automatic test_backpressure();
        int k;
        wait_idle();
        out_ready = 1'b0;
        A         = 32'h40C00000;
        B         = 32'h40000000;
        in_valid  = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        k = 0;
        while (!out_valid && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_valid got %b want 1", out_valid); end
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            total++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== 32'h40400000) begin
                bad++;
                $display("FAIL bp_hold[%0d] got valid=%b ready=%b result=%h want 1 0 40400000",
                         c, out_valid, in_ready, result);
            end
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++; $display("FAIL bp_release got ready=%b valid=%b want 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_ignore_mid_div();
        int k;
        wait_idle();
        A        = 32'h3F800000;
        B        = 32'h40400000;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        k = 0;
        while (!out_valid && k < 100) begin
            @(posedge clk); #1;
            k++;
            if (k == 5) begin
                A        = 32'h40C00000;
                B        = 32'h40000000;
                in_valid = 1'b1;
            end
            if (k >= 5 && k <= 8) begin
                total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL busy_ready[%0d] got %b want 0", k, in_ready); end
            end
            if (k == 8) in_valid = 1'b0;
        end
        total++; if (k !== 27) begin bad++; $display("FAIL busy_latency got %0d want 27", k); end
        total++; if (result !== 32'h3EAAAAAB) begin bad++; $display("FAIL busy_result got %h want 3EAAAAAB", result); end
        repeat (2) @(posedge clk);
        #1;
        total++; if (in_ready !== 1'b1 || out_valid !== 1'b0)
            begin bad++; $display("FAIL busy_no_queue got ready=%b valid=%b want 1 0", in_ready, out_valid); end
    endtask

    task automatic test_back_to_back();
        int k, nvalid, first_at, second_at, first_ready;
        wait_idle();
        A        = 32'h40C00000;
        B        = 32'h40000000;
        in_valid = 1'b1;
        @(posedge clk); #1;
        k = 0; nvalid = 0; first_at = 0; second_at = 0; first_ready = 0;
        while (nvalid < 2 && k < 200) begin
            @(posedge clk); #1;
            k++;
            if (in_ready && first_ready == 0) first_ready = k;
            if (out_valid) begin
                nvalid++;
                if (nvalid == 1) first_at = k; else second_at = k;
                total++; if (result !== 32'h40400000) begin bad++; $display("FAIL b2b_result[%0d] got %h want 40400000", nvalid, result); end
            end
        end
        in_valid = 1'b0;
        total++; if (first_at !== 27) begin bad++; $display("FAIL b2b_first got %0d want 27", first_at); end
        total++; if (first_ready !== 28) begin bad++; $display("FAIL b2b_ready got %0d want 28", first_ready); end
        total++; if (second_at !== 56) begin bad++; $display("FAIL b2b_second got %0d want 56", second_at); end
        repeat (2) @(posedge clk);
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_idle got %b want 1", in_ready); end
    endtask

    task automatic test_reset_mid_div();
        int lat; logic [31:0] res; logic [2:0] fl; bit ok;
        wait_idle();
        A        = 32'h40C00000;
        B        = 32'h40000000;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (12) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rstmid in_ready got %b want 1", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rstmid out_valid got %b want 0", out_valid); end
        total++; if (result !== 32'h0) begin bad++; $display("FAIL rstmid result got %h want 00000000", result); end
        total++; if ({overflow, underflow, div_by_zero} !== 3'b000)
            begin bad++; $display("FAIL rstmid flags got %b want 000", {overflow, underflow, div_by_zero}); end
        @(negedge clk);
        rst_n = 1'b1;
        do_op(32'h40C00000, 32'h40000000, lat, res, fl, ok);
        total++; if (!ok || res !== 32'h40400000) begin bad++; $display("FAIL rstmid_after result got %h want 40400000", res); end
        total++; if (lat !== 27) begin bad++; $display("FAIL rstmid_after latency got %0d want 27", lat); end
    endtask

    initial begin
        test_reset();
        test_arith();
        test_special();
        test_exp_edges();
        test_backpressure();
        test_ignore_mid_div();
        test_back_to_back();
        test_reset_mid_div();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
